// File: rtl/input_event_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : input_event_pkg
// Brief    : Shared line counts, index widths and event word type for the
//            board input event scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package input_event_pkg;

    localparam int NUM_BUTTONS  = 4;
    localparam int NUM_SWITCHES = 10;
    localparam int NUM_LINES    = NUM_BUTTONS + NUM_SWITCHES;
    localparam int IDX_W        = $clog2(NUM_LINES);
    localparam int BTN_BASE     = 0;
    localparam int SW_BASE      = NUM_BUTTONS;
    localparam int DROP_W       = 16;

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic             level;
    } evt_word_t;

    // Round-robin successor of a line index, wrapping at the last line.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NUM_LINES - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/input_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : input_debounce
// Brief    : One input line: 2-FF synchronizer, consecutive-difference
//            counter, stable level register and single-cycle accept pulse.
// Revision : 1.0 - initial release
// ============================================================================
module input_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_stable,
    output logic o_accept,
    output logic o_level
);

    localparam int               c_cnt_w    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_meta;
    logic               r_sync;
    logic               r_stable;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_accept;

    // Accept fires on the Nth consecutive cycle the synchronized level differs.
    assign w_accept = (r_sync != r_stable) && (r_cnt == c_cnt_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            if (r_sync == r_stable) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_sync;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    assign o_stable = r_stable;
    assign o_accept = w_accept;
    assign o_level  = r_sync;

endmodule
`default_nettype wire

// File: rtl/input_event_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : input_event_scheduler
// Brief    : Debounces buttons/switches, queues one pending event per line and
//            serves them round-robin over valid/ready with a level irq.
//            Optional drop counter: define INPUT_EVENT_DROP_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module input_event_scheduler
    import input_event_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_BUTTONS-1:0]  buttons,
    input  logic [NUM_SWITCHES-1:0] switches,
    input  logic [NUM_LINES-1:0]    event_mask,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [IDX_W-1:0]        evt_index,
    output logic                    evt_level,
    output logic                    irq,
`ifdef INPUT_EVENT_DROP_COUNT_EN
    input  logic                    drop_clear,
    output logic [DROP_W-1:0]       drop_count,
`endif
    output logic [NUM_LINES-1:0]    line_state
);

    logic [NUM_LINES-1:0] w_raw;
    logic [NUM_LINES-1:0] w_accept;
    logic [NUM_LINES-1:0] w_new_level;
    logic [NUM_LINES-1:0] w_set;
    logic [NUM_LINES-1:0] w_clear;
    logic [NUM_LINES-1:0] w_pending_next;
    logic                 w_load;
    logic                 w_found;
    logic [IDX_W-1:0]     w_grant_idx;
    logic                 w_valid_next;

    logic [NUM_LINES-1:0] r_pending;
    logic [NUM_LINES-1:0] r_lvl;
    logic [IDX_W-1:0]     r_ptr;
    logic                 r_valid;
    evt_word_t            r_word;
    logic                 r_irq;

    generate
        for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
            assign w_raw[BTN_BASE + i] = ~buttons[i];
        end
        for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_sw
            assign w_raw[SW_BASE + i] = switches[i];
        end
        for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
            input_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk      (clk),
                .reset    (reset),
                .i_raw    (w_raw[i]),
                .o_stable (line_state[i]),
                .o_accept (w_accept[i]),
                .o_level  (w_new_level[i])
            );
        end
    endgenerate

    // First pending line at or after the pointer, wrapping past the last line.
    always_comb begin
        logic [IDX_W:0] v_sum;
        logic [IDX_W-1:0] v_idx;
        w_found     = 1'b0;
        w_grant_idx = '0;
        v_sum       = '0;
        v_idx       = '0;
        for (int k = 0; k < NUM_LINES; k++) begin
            v_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
            if (v_sum >= (IDX_W+1)'(NUM_LINES)) begin
                v_sum = v_sum - (IDX_W+1)'(NUM_LINES);
            end
            v_idx = v_sum[IDX_W-1:0];
            if (!w_found && r_pending[v_idx]) begin
                w_found     = 1'b1;
                w_grant_idx = v_idx;
            end
        end
    end

    assign w_load         = !r_valid || evt_ready;
    assign w_set          = w_accept & event_mask;
    assign w_clear        = (w_load && w_found) ? (NUM_LINES'(1) << w_grant_idx) : '0;
    // A same-cycle accept re-arms a line being granted, so a second event follows.
    assign w_pending_next = (r_pending & ~w_clear) | w_set;
    assign w_valid_next   = w_load ? w_found : r_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
            r_lvl     <= '0;
            r_ptr     <= '0;
            r_valid   <= 1'b0;
            r_word    <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
            r_lvl     <= (r_lvl & ~w_accept) | (w_new_level & w_accept);
            r_irq     <= (|w_pending_next) | w_valid_next;
            if (w_load) begin
                r_valid <= w_found;
                if (w_found) begin
                    r_word.index <= w_grant_idx;
                    r_word.level <= r_lvl[w_grant_idx];
                    r_ptr        <= wrap_inc(w_grant_idx);
                end
            end
        end
    end

    assign evt_valid = r_valid;
    assign evt_index = r_word.index;
    assign evt_level = r_word.level;
    assign irq       = r_irq;

`ifdef INPUT_EVENT_DROP_COUNT_EN
    logic [NUM_LINES-1:0] w_coalesce;
    logic [IDX_W:0]       w_coalesce_cnt;
    logic [DROP_W:0]      w_drop_sum;
    logic [DROP_W-1:0]    r_drop;

    assign w_coalesce = w_accept & r_pending;

    always_comb begin
        w_coalesce_cnt = '0;
        for (int k = 0; k < NUM_LINES; k++) begin
            w_coalesce_cnt = w_coalesce_cnt + (IDX_W+1)'(w_coalesce[k]);
        end
    end

    assign w_drop_sum = {1'b0, r_drop} + (DROP_W+1)'(w_coalesce_cnt);

    always_ff @(posedge clk) begin
        if (reset || drop_clear) begin
            r_drop <= '0;
        end else begin
            r_drop <= w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
        end
    end

    assign drop_count = r_drop;
`endif

endmodule
`default_nettype wire

// File: tb/tb_input_event_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_input_event_scheduler
// Brief    : Self-checking bench: directed table, corner sequences and random
//            toggles against an event-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_event_scheduler;
    import input_event_pkg::*;

    localparam int c_deb = 4;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [NUM_BUTTONS-1:0]  buttons = '1;
    logic [NUM_SWITCHES-1:0] switches = '0;
    logic [NUM_LINES-1:0]    event_mask = '1;
    logic                    evt_valid;
    logic                    evt_ready = 1'b0;
    logic [IDX_W-1:0]        evt_index;
    logic                    evt_level;
    logic                    irq;
    logic [NUM_LINES-1:0]    line_state;
`ifdef INPUT_EVENT_DROP_COUNT_EN
    logic                    drop_clear = 1'b0;
    logic [DROP_W-1:0]       drop_count;
`endif

    input_event_scheduler #(.DEBOUNCE_CYCLES(c_deb)) dut (
        .clk        (clk),
        .reset      (reset),
        .buttons    (buttons),
        .switches   (switches),
        .event_mask (event_mask),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_index  (evt_index),
        .evt_level  (evt_level),
        .irq        (irq),
`ifdef INPUT_EVENT_DROP_COUNT_EN
        .drop_clear (drop_clear),
        .drop_count (drop_count),
`endif
        .line_state (line_state)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [3:0] idx; logic lvl; int cyc; } cap_t;
    typedef struct packed { logic [3:0] idx; logic lvl; } ev_t;
    typedef struct { int line; logic lvl; int hold; bit restore; int exp_n; logic exp_state; } vec_t;

    cap_t got_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   rand_rdy = 1'b0;
    logic [NUM_LINES-1:0] pins = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Completed handshakes, observed half a cycle before the accepting edge.
    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) got_q.push_back('{evt_index, evt_level, cyc});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) evt_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_pins();
        buttons  = ~pins[NUM_BUTTONS-1:0];
        switches = pins[NUM_LINES-1:NUM_BUTTONS];
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        logic [NUM_LINES-1:0] sel, msk, model_lvl;
        int   mptr, g, waited;
        ev_t  exp_q[$];

        tbl[0] = '{2,  1'b1, 3, 1'b1, 0, 1'b0};
        tbl[1] = '{2,  1'b1, 8, 1'b0, 1, 1'b1};
        tbl[2] = '{2,  1'b0, 8, 1'b0, 1, 1'b0};
        tbl[3] = '{6,  1'b1, 2, 1'b1, 0, 1'b0};
        tbl[4] = '{6,  1'b1, 6, 1'b0, 1, 1'b1};
        tbl[5] = '{13, 1'b1, 1, 1'b1, 0, 1'b0};
        tbl[6] = '{13, 1'b1, 5, 1'b0, 1, 1'b1};
        tbl[7] = '{6,  1'b0, 4, 1'b0, 1, 1'b0};
        tbl[8] = '{13, 1'b0, 3, 1'b1, 0, 1'b1};
        tbl[9] = '{13, 1'b0, 6, 1'b0, 1, 1'b0};

        // Reset and idle
        drive_pins();
        do_reset();
        repeat (50) tick();
        check("idle_valid", evt_valid, 0);
        check("idle_irq", irq, 0);
        check("idle_line_state", line_state, 0);

        // Single-line table: glitches rejected, long holds produce one event
        evt_ready = 1'b1;
        foreach (tbl[v]) begin
            got_q.delete();
            pins[tbl[v].line] = tbl[v].lvl;
            drive_pins();
            repeat (tbl[v].hold) tick();
            if (tbl[v].restore) begin
                pins[tbl[v].line] = ~tbl[v].lvl;
                drive_pins();
            end
            repeat (20) tick();
            check($sformatf("tbl%0d_count", v), got_q.size(), tbl[v].exp_n);
            if (tbl[v].exp_n == 1 && got_q.size() == 1) begin
                check($sformatf("tbl%0d_index", v), got_q[0].idx, tbl[v].line);
                check($sformatf("tbl%0d_level", v), got_q[0].lvl, tbl[v].lvl);
            end
            check($sformatf("tbl%0d_state", v), line_state[tbl[v].line], tbl[v].exp_state);
        end

        // Simultaneous switches: index order, one per cycle
        pins = '0; drive_pins();
        do_reset();
        evt_ready = 1'b1;
        got_q.delete();
        pins[4] = 1'b1; pins[9] = 1'b1; pins[13] = 1'b1;
        drive_pins();
        repeat (20) tick();
        check("multi_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("multi_idx0", got_q[0].idx, 4);
            check("multi_idx1", got_q[1].idx, 9);
            check("multi_idx2", got_q[2].idx, 13);
            check("multi_gap01", got_q[1].cyc - got_q[0].cyc, 1);
            check("multi_gap12", got_q[2].cyc - got_q[1].cyc, 1);
        end
        check("multi_irq_low", irq, 0);

        // irq leads evt_valid by one cycle
        evt_ready = 1'b0;
        pins[2] = 1'b1; drive_pins();
        waited = 0;
        while (!irq && waited < 40) begin
            tick();
            waited++;
        end
        check("irq_rise_seen", irq, 1);
        check("irq_before_valid", evt_valid, 0);
        tick();
        check("valid_after_irq", evt_valid, 1);
        check("irq_evt_index", evt_index, 2);
        check("irq_evt_level", evt_level, 1);
        evt_ready = 1'b1;
        repeat (3) tick();

        // Stalled handshake holds the word; pointer moves past the grant
        pins = '0; drive_pins();
        do_reset();
        evt_ready = 1'b0;
        pins[1] = 1'b1; pins[3] = 1'b1; drive_pins();
        repeat (12) tick();
        check("stall_valid", evt_valid, 1);
        check("stall_index", evt_index, 1);
        repeat (5) tick();
        check("stall_hold_index", evt_index, 1);
        evt_ready = 1'b1;
        tick();
        check("stall_next_valid", evt_valid, 1);
        check("stall_next_index", evt_index, 3);
        tick();
        check("stall_drained", evt_valid, 0);
        got_q.delete();
        pins[2] = 1'b1; pins[5] = 1'b1; drive_pins();
        repeat (15) tick();
        check("ptr_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("ptr_first", got_q[0].idx, 5);
            check("ptr_second", got_q[1].idx, 2);
        end

        // Coalescing while the output register is busy
        evt_ready = 1'b0;
`ifdef INPUT_EVENT_DROP_COUNT_EN
        drop_clear = 1'b1; tick(); drop_clear = 1'b0;
`endif
        pins[0] = 1'b1; drive_pins();
        repeat (12) tick();
        check("coal_busy_index", evt_index, 0);
        got_q.delete();
        pins[7] = 1'b1; drive_pins(); repeat (8) tick();
        pins[7] = 1'b0; drive_pins(); repeat (8) tick();
        pins[7] = 1'b1; drive_pins(); repeat (10) tick();
        check("coal_held_index", evt_index, 0);
`ifdef INPUT_EVENT_DROP_COUNT_EN
        check("coal_drop_count", drop_count, 2);
`endif
        evt_ready = 1'b1;
        repeat (10) tick();
        check("coal_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("coal_index", got_q[1].idx, 7);
            check("coal_level", got_q[1].lvl, 1);
        end

        // Masked accept is absorbed and never replayed
        pins = '0; drive_pins();
        do_reset();
        event_mask = 14'h3FFE;
        pins[0] = 1'b1; drive_pins();
        got_q.delete();
        repeat (20) tick();
        check("mask_line_state", line_state[0], 1);
        check("mask_no_event", got_q.size(), 0);
        check("mask_irq", irq, 0);
        event_mask = '1;
        repeat (5) tick();
        check("mask_no_replay", got_q.size(), 0);

        // Reset while an event is presented
        pins = '0; drive_pins();
        do_reset();
        evt_ready = 1'b0;
        pins[3] = 1'b1; pins[12] = 1'b1; drive_pins();
        repeat (12) tick();
        check("rst_pre_valid", evt_valid, 1);
        reset = 1'b1;
        tick();
        check("rst_valid", evt_valid, 0);
        check("rst_irq", irq, 0);
        check("rst_line_state", line_state, 0);
        pins = '0; pins[6] = 1'b1; drive_pins();
        repeat (3) tick();
        reset = 1'b0;
        evt_ready = 1'b1;
        got_q.delete();
        repeat (20) tick();
        check("post_rst_count", got_q.size(), 1);
        if (got_q.size() == 1) begin
            check("post_rst_index", got_q[0].idx, 6);
            check("post_rst_level", got_q[0].lvl, 1);
        end

        // Random toggles against the event-level model
        pins = '0; drive_pins();
        do_reset();
        model_lvl = '0;
        mptr = 0;
        for (int s = 0; s < 40; s++) begin
            sel = 14'($urandom) & 14'($urandom);
            if (sel == '0) sel = 14'(1) << $urandom_range(0, NUM_LINES - 1);
            msk = 14'($urandom) | 14'($urandom);
            event_mask = msk;
            evt_ready = 1'b1;
            tick();
            got_q.delete();
            exp_q.delete();
            if ($urandom_range(0, 3) == 0) begin
                g = $urandom_range(1, c_deb - 1);
                pins = model_lvl ^ sel; drive_pins();
                repeat (g) tick();
                pins = model_lvl; drive_pins();
                repeat (20) tick();
            end else begin
                for (int k = 0; k < NUM_LINES; k++) begin
                    int j;
                    j = (mptr + k) % NUM_LINES;
                    if (sel[j] && msk[j]) exp_q.push_back('{4'(j), ~model_lvl[j]});
                end
                model_lvl = model_lvl ^ sel;
                pins = model_lvl; drive_pins();
                rand_rdy = 1'b1;
                repeat (60) tick();
                rand_rdy = 1'b0;
                evt_ready = 1'b1;
                repeat (20) tick();
                if (exp_q.size() > 0) mptr = (int'(exp_q[exp_q.size() - 1].idx) + 1) % NUM_LINES;
            end
            check($sformatf("rnd%0d_count", s), got_q.size(), exp_q.size());
            for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
                check($sformatf("rnd%0d_ev%0d", s, k), {got_q[k].idx, got_q[k].lvl}, {exp_q[k].idx, exp_q[k].lvl});
            end
            check($sformatf("rnd%0d_state", s), line_state, model_lvl);
            check($sformatf("rnd%0d_irq", s), irq, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/input_event_scheduler.md
Name: input_event_scheduler

Overview:
- Debounces the 4 push-buttons and 10 slide switches and turns each accepted change into a discrete event.
- Queues one pending bit per line and serves the pending lines round-robin, one at a time, over a valid/ready handshake to the CPU-side interrupt handler.
- Drives a single level interrupt while work is outstanding.
- Sits between the board pins and the processor's interrupt/peripheral interface.

Parameters:
- NUM_BUTTONS, 4, button line count; buttons are raw active-low.
- NUM_SWITCHES, 10, switch line count; switches are active-high.
- DEBOUNCE_CYCLES, 50000, number of consecutive differing cycles before a change is accepted (1 ms at 50 MHz); must be ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- buttons  in  NUM_BUTTONS  raw button pins, active-low, asynchronous.
- switches  in  NUM_SWITCHES  raw switch pins, asynchronous.
- event_mask  in  NUM_LINES  1 = line may raise events. Line index: buttons 0..3, switches 4..13.
- evt_valid  out  1  event word presented.
- evt_ready  in  1  consumer accepts the event word.
- evt_index  out  IDX_W  line number of the presented event.
- evt_level  out  1  debounced new level (1 = pressed/on).
- irq  out  1  registered, high while any event is pending or presented.
- line_state  out  NUM_LINES  current debounced levels.

Behaviour:
- Clocking and reset:
  - Single clock; reset is synchronous and active-high.
  - Reset clears all synchronizers, stable levels, debounce counters, pending bits, level latches, the round-robin pointer, evt_valid, evt_index, evt_level, irq and line_state to 0.
- Input path:
  - Buttons are inverted first, so pressed = 1.
  - Every line then passes a 2-FF synchronizer (sync).
- Debounce, per line:
  - If sync == stable, cnt <= 0.
  - Otherwise cnt increments. On the cycle cnt == DEBOUNCE_CYCLES-1: stable <= sync, cnt <= 0, accept pulse.
  - A glitch shorter than DEBOUNCE_CYCLES is never accepted.
  - The counter restarts whenever sync returns to stable.
- Accept handling:
  - Accept always updates stable and line_state, and latches lvl[i] <= new level.
  - Accept sets pending[i] only if event_mask[i] = 1.
  - Masked accepts are silently absorbed. Unmasking later does not replay them.
- Coalescing:
  - An accept on a line that is already pending leaves pending set and overwrites lvl.
  - The consumer sees only the latest level.
- Output register:
  - Loads when evt_valid == 0 or (evt_valid && evt_ready).
  - If any pending bit is set, the first set bit at or after ptr (wrapping at NUM_LINES-1 → 0) is granted.
  - On grant: evt_index <= i, evt_level <= lvl[i], evt_valid <= 1, pending[i] cleared, ptr <= i+1 (wrapping).
  - If nothing is pending, evt_valid <= 0.
- Handshake:
  - evt_index and evt_level are held stable while evt_valid && !evt_ready.
  - Back-to-back acceptance gives one event per cycle.
- Simultaneous set and clear on the same line: set wins, so pending stays 1. A second event follows.
- Latency: accept in cycle N → pending in N+1 → evt_valid in N+2 when the output register is idle.
- irq: irq <= (|pending_next) | evt_valid_next, registered, one output flop.
- Post-reset: a switch already on produces one event, level 1, after synchronizer + DEBOUNCE_CYCLES. Idle buttons produce none.
- Reset asserted mid-handshake drops the presented event and all pending events.

Optional Feature:
- Macro: INPUT_EVENT_DROP_COUNT_EN.
- When defined:
  - Adds output drop_count, 16 bits: a saturating count (stops at 0xFFFF) of coalesced accepts, i.e. accept while pending[i] is already 1. Simultaneous coalesces on k lines add k.
  - Adds input drop_clear (1 bit), a synchronous clear; clear wins over a same-cycle increment.
  - drop_count resets to 0.
- When undefined: neither port exists and no counter logic is present.

Decomposition:
- Package input_event_pkg holds:
  - NUM_LINES = NUM_BUTTONS + NUM_SWITCHES (14).
  - IDX_W = $clog2(NUM_LINES) (4).
  - BTN_BASE = 0, SW_BASE = NUM_BUTTONS.
  - DROP_W = 16.
- Sub-module input_debounce:
  - One line: synchronizer, counter, stable level, accept pulse.
  - Parameter DEBOUNCE_CYCLES.
  - Instantiated NUM_LINES times by generate.
- Pending, arbiter and output register stay in the top module.

Test Plan (bench uses DEBOUNCE_CYCLES = 4):
- Reset, then hold buttons = 4'hF, switches = 0, mask = all 1s for 50 cycles → evt_valid = 0, irq = 0, line_state = 0.
- Drive buttons[2] low for 3 cycles only → no event. Hold it low for ≥6 cycles → one event {index 2, level 1}, and irq rises one cycle before evt_valid.
- Set switches[0], [5] and [9] on the same cycle with evt_ready = 1 → events in index order 4, 9, 13, one per cycle, then irq = 0.
- Hold evt_ready = 0 with lines 1 and 3 pending → evt_index stays 1 and line 3 stays pending. Raise evt_ready → index 3 follows; the next scan starts at ptr = 4.
- Toggle switches[3] on→off→on, each level held ≥6 cycles, while evt_ready = 0 → one event for index 7 with level 1. With the macro defined, drop_count = 2.
- Clear event_mask[0] and press button 0 → line_state[0] = 1 and no event. Assert reset while an event is presented → next cycle evt_valid = 0, irq = 0, line_state = 0.
